rtc_bcd_source: RTL and testbench

//  Free-running BCD time-of-day keeper that drives the 65-bit RTC bus consumed by the slot clock card.

---
 rtl/rtc_bcd_source.sv | 238 +++++++++++++++++++++++
 tb/tb_rtc_bcd_source.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_source.sv
// rtc_bcd_source: BCD time-of-day keeper driving the 65-bit RTC bus.
// A prescaler derives a once-per-second tick from CLK_14M. A small FSM then
// ripples the carry through the time fields, one field per cycle. The result
// is published on RTC_OUT together with a flip of the update toggle in RTC_OUT[64].
module rtc_bcd_source #(
  parameter int CLK_HZ = 14318181
) (
  input  logic        CLK_14M,
  input  logic        RESET_N,
  input  logic        LOAD,
  input  logic [50:0] LOAD_TIME,
  output logic        LOAD_READY,
  output logic [64:0] RTC_OUT,
  output logic        SEC_PULSE
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TERMINAL = PW'(CLK_HZ - 1);

  // 2000-01-01 00:00:00, Saturday
  localparam logic [50:0] RESET_FIELDS = {3'd6, 8'h00, 3'b000, 1'b0, 4'h1,
                                          2'b00, 2'd0, 4'h1, 2'b00, 2'd0, 4'h0,
                                          1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0};

  typedef enum logic [2:0] {IDLE, SEC, MIN, HOUR, DAY, MON, YEAR, PUBLISH} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic          load_accept;

  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic [3:0] hour_ones;
  logic [1:0] hour_tens;
  logic [3:0] day_ones;
  logic [1:0] day_tens;
  logic [3:0] mon_ones;
  logic       mon_tens;
  logic [3:0] year_ones;
  logic [3:0] year_tens;
  logic [2:0] dow;

  logic [50:0] fields;
  logic [7:0]  month_len;
  logic        leap_year;
  logic        load_time_unused;

  assign tick        = (prescaler == TERMINAL);
  assign SEC_PULSE   = tick;
  assign load_accept = LOAD && (state == IDLE);

  // Bits of LOAD_TIME that have no field behind them are dropped on load
  assign load_time_unused = ^{LOAD_TIME[7], LOAD_TIME[15], LOAD_TIME[23:22],
                              LOAD_TIME[31:30], LOAD_TIME[39:37]};

  assign fields = {dow, year_tens, year_ones, 3'b000, mon_tens, mon_ones,
                   2'b00, day_tens, day_ones, 2'b00, hour_tens, hour_ones,
                   1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};

  // Leap year from the BCD year digits: year%4==0 (00 counts as leap)
  always_comb begin
    leap_year = 1'b0;
    case (year_ones)
      4'h0, 4'h4, 4'h8: leap_year = ~year_tens[0];
      4'h2, 4'h6:       leap_year = year_tens[0];
      default:          leap_year = 1'b0;
    endcase
  end

  // Last valid day of the current month, in BCD
  always_comb begin
    month_len = 8'h31;
    case ({3'b000, mon_tens, mon_ones})
      8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
      8'h02:                      month_len = leap_year ? 8'h29 : 8'h28;
      default:                    month_len = 8'h31;
    endcase
  end

  // Free-running prescaler; an accepted load restarts the second
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      prescaler <= '0;
    end else if (load_accept || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Carry-ripple FSM: one field per cycle, RTC_OUT written only in PUBLISH
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      LOAD_READY <= 1'b1;
      sec_ones   <= 4'h0;
      sec_tens   <= 3'd0;
      min_ones   <= 4'h0;
      min_tens   <= 3'd0;
      hour_ones  <= 4'h0;
      hour_tens  <= 2'd0;
      day_ones   <= 4'h1;
      day_tens   <= 2'd0;
      mon_ones   <= 4'h1;
      mon_tens   <= 1'b0;
      year_ones  <= 4'h0;
      year_tens  <= 4'h0;
      dow        <= 3'd6;
      RTC_OUT    <= {1'b0, 13'b0, RESET_FIELDS};
    end else begin
      case (state)
        IDLE: begin
          if (LOAD) begin
            sec_ones   <= LOAD_TIME[3:0];
            sec_tens   <= LOAD_TIME[6:4];
            min_ones   <= LOAD_TIME[11:8];
            min_tens   <= LOAD_TIME[14:12];
            hour_ones  <= LOAD_TIME[19:16];
            hour_tens  <= LOAD_TIME[21:20];
            day_ones   <= LOAD_TIME[27:24];
            day_tens   <= LOAD_TIME[29:28];
            mon_ones   <= LOAD_TIME[35:32];
            mon_tens   <= LOAD_TIME[36];
            year_ones  <= LOAD_TIME[43:40];
            year_tens  <= LOAD_TIME[47:44];
            dow        <= LOAD_TIME[50:48];
            state      <= PUBLISH;
            LOAD_READY <= 1'b0;
          end else if (tick) begin
            state      <= SEC;
            LOAD_READY <= 1'b0;
          end
        end
        SEC: begin
          if ({1'b0, sec_tens, sec_ones} >= 8'h59) begin
            sec_tens <= 3'd0;
            sec_ones <= 4'h0;
            state    <= MIN;
          end else begin
            if (sec_ones >= 4'h9) begin
              sec_ones <= 4'h0;
              sec_tens <= sec_tens + 3'd1;
            end else begin
              sec_ones <= sec_ones + 4'h1;
            end
            state <= PUBLISH;
          end
        end
        MIN: begin
          if ({1'b0, min_tens, min_ones} >= 8'h59) begin
            min_tens <= 3'd0;
            min_ones <= 4'h0;
            state    <= HOUR;
          end else begin
            if (min_ones >= 4'h9) begin
              min_ones <= 4'h0;
              min_tens <= min_tens + 3'd1;
            end else begin
              min_ones <= min_ones + 4'h1;
            end
            state <= PUBLISH;
          end
        end
        HOUR: begin
          if ({2'b00, hour_tens, hour_ones} >= 8'h23) begin
            hour_tens <= 2'd0;
            hour_ones <= 4'h0;
            state     <= DAY;
          end else begin
            if (hour_ones >= 4'h9) begin
              hour_ones <= 4'h0;
              hour_tens <= hour_tens + 2'd1;
            end else begin
              hour_ones <= hour_ones + 4'h1;
            end
            state <= PUBLISH;
          end
        end
        DAY: begin
          dow <= (dow >= 3'd6) ? 3'd0 : dow + 3'd1;
          if ({2'b00, day_tens, day_ones} >= month_len) begin
            day_tens <= 2'd0;
            day_ones <= 4'h1;
            state    <= MON;
          end else begin
            if (day_ones >= 4'h9) begin
              day_ones <= 4'h0;
              day_tens <= day_tens + 2'd1;
            end else begin
              day_ones <= day_ones + 4'h1;
            end
            state <= PUBLISH;
          end
        end
        MON: begin
          if ({3'b000, mon_tens, mon_ones} >= 8'h12) begin
            mon_tens <= 1'b0;
            mon_ones <= 4'h1;
            state    <= YEAR;
          end else begin
            if (mon_ones >= 4'h9) begin
              mon_ones <= 4'h0;
              mon_tens <= 1'b1;
            end else begin
              mon_ones <= mon_ones + 4'h1;
            end
            state <= PUBLISH;
          end
        end
        YEAR: begin
          if ({year_tens, year_ones} >= 8'h99) begin
            year_tens <= 4'h0;
            year_ones <= 4'h0;
          end else if (year_ones >= 4'h9) begin
            year_ones <= 4'h0;
            year_tens <= year_tens + 4'h1;
          end else begin
            year_ones <= year_ones + 4'h1;
          end
          state <= PUBLISH;
        end
        PUBLISH: begin
          RTC_OUT    <= {~RTC_OUT[64], 13'b0, fields};
          state      <= IDLE;
          LOAD_READY <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          LOAD_READY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bcd_source.sv
// tb_rtc_bcd_source: self-checking bench for rtc_bcd_source with a 10-cycle second.
// Every expected publish is queued with its due cycle. A negedge monitor pops
// the queue whenever the update toggle moves.
module tb_rtc_bcd_source;

  localparam int CLK_HZ = 10;

  logic        CLK_14M;
  logic        RESET_N;
  logic        LOAD;
  logic [50:0] LOAD_TIME;
  logic        LOAD_READY;
  logic [64:0] RTC_OUT;
  logic        SEC_PULSE;

  typedef struct {
    logic [64:0] value;
    int          due;
  } expect_t;

  typedef struct {
    logic [50:0] loadTime;
    logic [50:0] afterTick;
    int          lat;
  } vec_t;

  expect_t     expQ[$];
  vec_t        vecs[16];
  int          cyc;
  int          checks;
  int          errors;
  logic        expTog;
  logic        prevTog;
  logic [50:0] fieldMask;
  logic [64:0] resetVal;

  rtc_bcd_source #(.CLK_HZ(CLK_HZ)) dut (
    .CLK_14M    (CLK_14M),
    .RESET_N    (RESET_N),
    .LOAD       (LOAD),
    .LOAD_TIME  (LOAD_TIME),
    .LOAD_READY (LOAD_READY),
    .RTC_OUT    (RTC_OUT),
    .SEC_PULSE  (SEC_PULSE)
  );

  // Free-running clock
  initial begin
    CLK_14M = 1'b0;
    forever #5 CLK_14M = ~CLK_14M;
  end

  // Cycle counter, advanced on every active edge
  initial begin
    cyc = 0;
    forever begin
      @(posedge CLK_14M);
      cyc++;
    end
  end

  // Packs BCD date/time digits into the bus layout
  function automatic logic [50:0] mk(input logic [2:0] dw, input logic [7:0] yy,
                                     input logic [7:0] mo, input logic [7:0] dd,
                                     input logic [7:0] hh, input logic [7:0] mi,
                                     input logic [7:0] ss);
    logic [50:0] r;
    r = '0;
    r[50:48] = dw;
    r[47:40] = yy;
    r[36:32] = mo[4:0];
    r[29:24] = dd[5:0];
    r[21:16] = hh[5:0];
    r[14:8]  = mi[6:0];
    r[6:0]   = ss[6:0];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [64:0] actual,
                             input logic [64:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input logic [50:0] f, input int due);
    expect_t e;
    expTog  = ~expTog;
    e.value = {expTog, 13'b0, f};
    e.due   = due;
    expQ.push_back(e);
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) @(negedge CLK_14M);
  endtask

  // Loads a value, queues its publish and the next tick's result, and records
  // SEC_PULSE over the following 19 cycles; returns on the negedge of load+19.
  task automatic applyStimulus(input logic [50:0] ld, input logic [50:0] res,
                               input int lat, output logic [19:0] pmask);
    int c;
    c = cyc;
    LOAD      = 1'b1;
    LOAD_TIME = ld;
    pushExpect(ld & fieldMask, c + 2);
    pushExpect(res, c + CLK_HZ + lat);
    pmask = '0;
    @(negedge CLK_14M);
    LOAD = 1'b0;
    for (int k = 1; k < 20; k++) begin
      pmask[k] = SEC_PULSE;
      if (k < 19) @(negedge CLK_14M);
    end
  endtask

  // Publish monitor: each toggle change must match the head of the queue
  initial begin
    expect_t item;
    prevTog = 1'b0;
    forever begin
      @(negedge CLK_14M);
      if (RESET_N !== 1'b1) begin
        prevTog = RTC_OUT[64];
      end else if (RTC_OUT[64] !== prevTog) begin
        prevTog = RTC_OUT[64];
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedPublish: got %0h with nothing expected", RTC_OUT);
        end else begin
          item = expQ.pop_front();
          checkOutput("publishValue", RTC_OUT, item.value);
          checkOutput("publishCycle", 65'(cyc), 65'(item.due));
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          r;
    int          c;
    int          c0;
    int          c1;
    int          r2;
    logic [24:0] runMask;
    logic [19:0] pmask;
    logic        found;
    logic [50:0] ld4;

    checks    = 0;
    errors    = 0;
    expTog    = 1'b0;
    RESET_N   = 1'b0;
    LOAD      = 1'b0;
    LOAD_TIME = '0;
    fieldMask = mk(3'h7, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff);
    resetVal  = {1'b0, 13'b0, mk(3'd6, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00)};

    vecs[0]  = '{mk(0, 8'h23, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59), mk(1, 8'h24, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00), 8};
    vecs[1]  = '{mk(3, 8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59), mk(4, 8'h24, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00), 6};
    vecs[2]  = '{mk(2, 8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59), mk(3, 8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00), 7};
    vecs[3]  = '{mk(2, 8'h24, 8'h04, 8'h30, 8'h23, 8'h59, 8'h59), mk(3, 8'h24, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00), 7};
    vecs[4]  = '{mk(4, 8'h10, 8'h06, 8'h15, 8'h12, 8'h34, 8'h56), mk(4, 8'h10, 8'h06, 8'h15, 8'h12, 8'h34, 8'h57), 3};
    vecs[5]  = '{mk(4, 8'h10, 8'h06, 8'h15, 8'h12, 8'h34, 8'h59), mk(4, 8'h10, 8'h06, 8'h15, 8'h12, 8'h35, 8'h00), 4};
    vecs[6]  = '{mk(5, 8'h10, 8'h06, 8'h15, 8'h09, 8'h59, 8'h59), mk(5, 8'h10, 8'h06, 8'h15, 8'h10, 8'h00, 8'h00), 5};
    vecs[7]  = '{mk(6, 8'h21, 8'h06, 8'h30, 8'h23, 8'h59, 8'h59), mk(0, 8'h21, 8'h07, 8'h01, 8'h00, 8'h00, 8'h00), 7};
    vecs[8]  = '{mk(1, 8'h00, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59), mk(2, 8'h00, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00), 6};
    vecs[9]  = '{mk(1, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59), mk(2, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00), 8};
    vecs[10] = '{mk(1, 8'h19, 8'h09, 8'h30, 8'h23, 8'h59, 8'h59), mk(2, 8'h19, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00), 7};
    vecs[11] = '{mk(3, 8'h22, 8'h07, 8'h19, 8'h23, 8'h59, 8'h59), mk(4, 8'h22, 8'h07, 8'h20, 8'h00, 8'h00, 8'h00), 6};
    vecs[12] = '{mk(3, 8'h22, 8'h07, 8'h19, 8'h08, 8'h14, 8'h5A), mk(3, 8'h22, 8'h07, 8'h19, 8'h08, 8'h15, 8'h00), 4};
    vecs[13] = '{mk(0, 8'h22, 8'h11, 8'h30, 8'h23, 8'h59, 8'h59), mk(1, 8'h22, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00), 7};
    vecs[14] = '{mk(4, 8'h24, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59), mk(5, 8'h24, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00), 7};
    vecs[15] = '{mk(2, 8'h12, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59), mk(3, 8'h12, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00), 6};

    // Reset state
    repeat (3) @(negedge CLK_14M);
    checkOutput("resetRtc", RTC_OUT, resetVal);
    checkOutput("resetReady", 65'(LOAD_READY), 65'(1));
    checkOutput("resetPulse", 65'(SEC_PULSE), 65'(0));

    // Free run after reset: two ticks, toggle goes 1 then 0
    $display("[TB] free run after reset");
    RESET_N = 1'b1;
    r = cyc;
    expTog = 1'b0;
    pushExpect(mk(3'd6, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01), r + 12);
    pushExpect(mk(3'd6, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02), r + 22);
    runMask = '0;
    for (int k = 0; k < 25; k++) begin
      runMask[k] = SEC_PULSE;
      @(negedge CLK_14M);
    end
    checkOutput("pulseCycles", 65'(runMask), 65'((25'd1 << 9) | (25'd1 << 19)));

    // Table of loads, each followed by one tick
    $display("[TB] table vectors");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].loadTime, vecs[i].afterTick, vecs[i].lat, pmask);
      checkOutput("vecPulseSpacing", 65'(pmask), 65'(20'd1 << 10));
    end

    // Load on the terminal-count cycle: load wins, prescaler restarts
    $display("[TB] load on terminal count");
    c = cyc;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (SEC_PULSE === 1'b1) found = 1'b1;
      else @(negedge CLK_14M);
    end
    checkOutput("terminalFound", 65'(found), 65'(1));
    checkOutput("terminalAlign", 65'(cyc - c), 65'(1));
    ld4 = mk(2, 8'h24, 8'h07, 8'h04, 8'h11, 8'h22, 8'h33) | 51'h80 | (51'h1 << 39);
    applyStimulus(ld4, mk(2, 8'h24, 8'h07, 8'h04, 8'h11, 8'h22, 8'h34), 3, pmask);
    checkOutput("collidePulseSpacing", 65'(pmask), 65'(20'd1 << 10));

    // Load while busy in MIN is ignored and does not restart the prescaler
    $display("[TB] load while busy");
    c0 = cyc;
    LOAD      = 1'b1;
    LOAD_TIME = mk(2, 8'h15, 8'h03, 8'h10, 8'h12, 8'h34, 8'h59);
    pushExpect(LOAD_TIME, c0 + 2);
    pushExpect(mk(2, 8'h15, 8'h03, 8'h10, 8'h12, 8'h35, 8'h00), c0 + 14);
    pushExpect(mk(2, 8'h15, 8'h03, 8'h10, 8'h12, 8'h35, 8'h01), c0 + 23);
    @(negedge CLK_14M);
    LOAD = 1'b0;
    waitCycle(c0 + 12);
    checkOutput("busyReady", 65'(LOAD_READY), 65'(0));
    LOAD      = 1'b1;
    LOAD_TIME = mk(0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
    @(negedge CLK_14M);
    LOAD = 1'b0;
    waitCycle(c0 + 14);
    checkOutput("readyAgain", 65'(LOAD_READY), 65'(1));
    waitCycle(c0 + 20);
    checkOutput("busyPulseKept", 65'(SEC_PULSE), 65'(1));
    waitCycle(c0 + 25);

    // Reset during the HOUR state: immediate reset value, no toggle
    $display("[TB] reset mid-sequence");
    c1 = cyc;
    LOAD      = 1'b1;
    LOAD_TIME = mk(2, 8'h24, 8'h04, 8'h30, 8'h23, 8'h59, 8'h59);
    pushExpect(LOAD_TIME, c1 + 2);
    @(negedge CLK_14M);
    LOAD = 1'b0;
    waitCycle(c1 + 13);
    checkOutput("hourBusy", 65'(LOAD_READY), 65'(0));
    RESET_N = 1'b0;
    #1;
    checkOutput("midResetRtc", RTC_OUT, resetVal);
    checkOutput("midResetReady", 65'(LOAD_READY), 65'(1));
    checkOutput("midResetPulse", 65'(SEC_PULSE), 65'(0));
    repeat (3) @(negedge CLK_14M);
    checkOutput("heldResetRtc", RTC_OUT, resetVal);
    RESET_N = 1'b1;
    r2 = cyc;
    expTog = 1'b0;
    pushExpect(mk(3'd6, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01), r2 + 12);
    waitCycle(r2 + 15);

    // Drain anything still outstanding
    for (int k = 0; k < 30 && expQ.size() > 0; k++) @(negedge CLK_14M);
    checkOutput("queueDrained", 65'(expQ.size()), 65'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
